// File: rtl/shift_norm_pkg.sv
// Shared types and helpers for the iterative shift normalizer.
// Optional fast path in the top level is enabled by SHIFT_NORM_FAST_PATH_EN.
package shift_norm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 32;
    localparam int MAX_WIDTH     = 256;

    // Low-aligned mask of 2^k ones; callers size-cast it down to their width.
    function automatic logic [MAX_WIDTH-1:0] stage_mask(input int unsigned k);
        logic [MAX_WIDTH-1:0] one;
        one = MAX_WIDTH'(1);
        return (one << (32'd1 << k)) - one;
    endfunction

endpackage

// File: rtl/shift_normalizer_seq_norm_stage.sv
// One binary-search stage: tests the 2^k-bit edge window of the work word
// and shifts it out when that window is all zeros.
module norm_stage
    import shift_norm_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] work_i,
    input  logic [SW-1:0]    k_i,
    input  logic             right_i,
    output logic [WIDTH-1:0] work_o,
    output logic             hit_o
);

    logic [WIDTH-1:0] lo_mask;
    logic [WIDTH-1:0] hi_mask;
    int unsigned      step;

    always_comb begin
        step    = 32'd1 << k_i;
        lo_mask = WIDTH'(stage_mask(32'(k_i)));
        hi_mask = lo_mask << (32'(WIDTH) - step);
        hit_o   = 1'b0;
        work_o  = work_i;
        if (right_i) begin
            hit_o = ~|(work_i & lo_mask);
            if (hit_o) work_o = work_i >> step;
        end else begin
            hit_o = ~|(work_i & hi_mask);
            if (hit_o) work_o = work_i << step;
        end
    end

endmodule

// File: rtl/shift_normalizer_seq.sv
// Iterative leading/trailing-zero normalizer, one search stage per clock.
// Define SHIFT_NORM_FAST_PATH_EN to bypass the search for normalized or zero words.
module shift_normalizer_seq
    import shift_norm_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     right_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [WIDTH-1:0]         o_y,
    output logic [$clog2(WIDTH)-1:0] s_o,
    output logic                     zero_o
);

    localparam int SW = $clog2(WIDTH);

    state_e           state_q;
    logic [WIDTH-1:0] work_q;
    logic             mode_q;
    logic [SW-1:0]    cnt_q;
    logic [SW-1:0]    k_q;
    logic             valid_q;
    logic [WIDTH-1:0] y_q;
    logic [SW-1:0]    s_q;
    logic             zero_q;

    logic [WIDTH-1:0] stage_work;
    logic             stage_hit;
    logic             accept;

    norm_stage #(
        .WIDTH (WIDTH),
        .SW    (SW)
    ) u_stage (
        .work_i  (work_q),
        .k_i     (k_q),
        .right_i (mode_q),
        .work_o  (stage_work),
        .hit_o   (stage_hit)
    );

    assign ready_o = (state_q == IDLE) | ((state_q == DONE) & ready_i);
    assign accept  = valid_i & ready_o;

`ifdef SHIFT_NORM_FAST_PATH_EN
    logic fast_norm;
    logic fast_zero;
    assign fast_norm = right_i ? data_i[0] : data_i[WIDTH-1];
    assign fast_zero = ~|data_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            work_q  <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            k_q     <= '0;
            valid_q <= 1'b0;
            y_q     <= '0;
            s_q     <= '0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        work_q  <= data_i;
                        mode_q  <= right_i;
                        cnt_q   <= '0;
                        k_q     <= SW'(SW - 1);
                        valid_q <= 1'b0;
                        state_q <= SEARCH;
`ifdef SHIFT_NORM_FAST_PATH_EN
                        if (fast_zero) begin
                            state_q <= DONE;
                            valid_q <= 1'b1;
                            y_q     <= '0;
                            s_q     <= SW'(WIDTH - 1);
                            zero_q  <= 1'b1;
                        end else if (fast_norm) begin
                            state_q <= DONE;
                            valid_q <= 1'b1;
                            y_q     <= data_i;
                            s_q     <= '0;
                            zero_q  <= 1'b0;
                        end
`endif
                    end else if ((state_q == DONE) && ready_i) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                SEARCH: begin
                    work_q <= stage_work;
                    cnt_q  <= cnt_q | (SW'(stage_hit) << k_q);
                    k_q    <= k_q - 1'b1;
                    // Stage 0 closes the search; its hit is bit 0 of the count.
                    if (k_q == '0) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        y_q     <= stage_work;
                        s_q     <= cnt_q | SW'(stage_hit);
                        zero_q  <= ~|stage_work;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign valid_o = valid_q;
    assign o_y     = y_q;
    assign s_o     = s_q;
    assign zero_o  = zero_q;

endmodule

// File: tb/tb_shift_normalizer_seq.sv
// Directed self-checking bench for shift_normalizer_seq (WIDTH=32).
module tb_shift_normalizer_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] data_i;
    logic        right_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] o_y;
    logic [4:0]  s_o;
    logic        zero_o;

    int vectors     = 0;
    int miscompares = 0;

`ifdef SHIFT_NORM_FAST_PATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    shift_normalizer_seq #(.WIDTH(32)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .right_i (right_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .o_y     (o_y),
        .s_o     (s_o),
        .zero_o  (zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits for valid_o counting the accept edge as edge 1, then checks results.
    task automatic wait_result(input string tag, input int exp_lat, input logic [31:0] ey,
                               input logic [4:0] es, input logic ez);
        int lat;
        lat = 1;
        while (!valid_o && lat < 20) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_y"}, o_y, ey);
        chk({tag, "_s"}, 32'(s_o), 32'(es));
        chk({tag, "_zero"}, 32'(zero_o), 32'(ez));
    endtask

    task automatic run_vec(input string tag, input logic [31:0] d, input logic r,
                           input logic [31:0] ey, input logic [4:0] es, input logic ez,
                           input bit quick);
        int exp_lat;
        exp_lat = (FAST && quick) ? 1 : 6;
        @(negedge clk_i);
        chk({tag, "_rdy"}, 32'(ready_o), 32'd1);
        valid_i = 1'b1;
        data_i  = d;
        right_i = r;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        data_i  = $urandom;
        right_i = ~r;
        wait_result(tag, exp_lat, ey, es, ez);
        @(negedge clk_i);
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk({tag, "_handoff"}, 32'(valid_o), 32'd0);
        ready_i = 1'b0;
    endtask

    initial begin
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        right_i = 1'b0;
        data_i  = '0;
        #12;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_y", o_y, 32'd0);
        chk("rst_s", 32'(s_o), 32'd0);
        chk("rst_zero", 32'(zero_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;

        run_vec("left_f0",   32'h00F0_0000, 1'b0, 32'hF000_0000, 5'd8,  1'b0, 1'b0);
        run_vec("right_1234",32'h1234_5678, 1'b1, 32'h0246_8ACF, 5'd3,  1'b0, 1'b0);
        run_vec("left_norm", 32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5, 5'd0,  1'b0, 1'b1);
        run_vec("right_norm",32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5, 5'd0,  1'b0, 1'b1);
        run_vec("zero_left", 32'h0000_0000, 1'b0, 32'h0000_0000, 5'd31, 1'b1, 1'b1);
        run_vec("zero_right",32'h0000_0000, 1'b1, 32'h0000_0000, 5'd31, 1'b1, 1'b1);
        run_vec("left_one",  32'h0000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b0, 1'b0);
        run_vec("right_msb", 32'h8000_0000, 1'b1, 32'h0000_0001, 5'd31, 1'b0, 1'b0);

        // Backpressure in DONE, then accept a new word on the releasing edge.
        @(negedge clk_i);
        valid_i = 1'b1;
        data_i  = 32'h0000_0001;
        right_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("bp_busy_ready", 32'(ready_o), 32'd0);
        wait_result("bp_first", 6, 32'h8000_0000, 5'd31, 1'b0);
        valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("bp_hold_valid", 32'(valid_o), 32'd1);
            chk("bp_hold_y", o_y, 32'h8000_0000);
            chk("bp_hold_s", 32'(s_o), 32'd31);
            chk("bp_hold_ready", 32'(ready_o), 32'd0);
        end
        @(negedge clk_i);
        ready_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 32'h00F0_0000;
        right_i = 1'b1;
        #1;
        chk("bp_release_ready", 32'(ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        valid_i = 1'b0;
        chk("bp_reaccept_valid", 32'(valid_o), 32'd0);
        chk("bp_keep_y", o_y, 32'h8000_0000);
        wait_result("bp_second", 6, 32'h0000_000F, 5'd20, 1'b0);
        @(negedge clk_i);
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;

        // Reset pulse while the search sits at stage 2.
        @(negedge clk_i);
        valid_i = 1'b1;
        data_i  = 32'h0001_0000;
        right_i = 1'b0;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(valid_o), 32'd0);
        chk("mid_rst_y", o_y, 32'd0);
        chk("mid_rst_s", 32'(s_o), 32'd0);
        chk("mid_rst_zero", 32'(zero_o), 32'd0);
        chk("mid_rst_ready", 32'(ready_o), 32'd1);
        repeat (8) @(posedge clk_i);
        #1;
        chk("mid_rst_no_output", 32'(valid_o), 32'd0);

        run_vec("post_rst", 32'h0001_0000, 1'b0, 32'h8000_0000, 5'd15, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
